// File: rtl/regs_port_ctrl_if.sv
// ============================================================================
//  Module      : regs_port_ctrl_if
//  Description : Bus bundle between regs_port_ctrl, its two write requesters,
//                the host read port and the picoMIPS 4 x N register file.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regs_port_ctrl_if #(
    parameter int N = 8
);
    logic           core_wvalid;
    logic           core_wready;
    logic [1:0]     core_waddr;
    logic [N-1:0]   core_wdata;

    logic           host_wvalid;
    logic           host_wready;
    logic [1:0]     host_waddr;
    logic [N-1:0]   host_wdata;

    logic           host_rvalid;
    logic           host_rready;
    logic [1:0]     host_raddr;
    logic [N-1:0]   host_rdata;
    logic           host_rdvalid;

    logic           core_rd2_idle;
    logic [1:0]     core_raddr2;
    logic           core_stall;

    logic           rf_w;
    logic [1:0]     rf_waddr;
    logic [N-1:0]   rf_wdata;
    logic [1:0]     rf_raddr2;
    logic [N-1:0]   rf_rdata2;

    modport slave (
        input  core_wvalid, core_waddr, core_wdata,
        output core_wready,
        input  host_wvalid, host_waddr, host_wdata,
        output host_wready,
        input  host_rvalid, host_raddr,
        output host_rready, host_rdata, host_rdvalid,
        input  core_rd2_idle, core_raddr2,
        output core_stall,
        output rf_w, rf_waddr, rf_wdata, rf_raddr2,
        input  rf_rdata2
    );

    modport master (
        output core_wvalid, core_waddr, core_wdata,
        input  core_wready,
        output host_wvalid, host_waddr, host_wdata,
        input  host_wready,
        output host_rvalid, host_raddr,
        input  host_rready, host_rdata, host_rdvalid,
        output core_rd2_idle, core_raddr2,
        input  core_stall,
        input  rf_w, rf_waddr, rf_wdata, rf_raddr2,
        output rf_rdata2
    );
endinterface

`default_nettype wire

// File: rtl/regs_port_ctrl.sv
// ============================================================================
//  Module      : regs_port_ctrl
//  Description : Round-robin write-port arbiter and host read-port borrower
//                for the picoMIPS 4 x N register file.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regs_port_ctrl #(
    parameter int          N        = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  wire logic          clk,
    input  wire logic          nreset,
    regs_port_ctrl_if.slave    io_bus
);

    localparam int unsigned          c_CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [c_CNT_W-1:0]   c_WAIT_MAX = c_CNT_W'(MAX_WAIT);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } rd_state_t;

    rd_state_t            r_state;
    rd_state_t            w_state_nxt;

    logic                 r_last_host;
    logic                 r_stg_valid;
    logic [1:0]           r_stg_addr;
    logic [N-1:0]         r_stg_data;

    logic [1:0]           r_raddr;
    logic [c_CNT_W-1:0]   r_wait_cnt;
    logic [N-1:0]         r_rdata;
    logic                 r_rdvalid;

    logic                 w_core_gnt;
    logic                 w_host_gnt;
    logic                 w_conflict;
    logic                 w_rready;
    logic                 w_accept;
    logic                 w_cnt_max;
    logic                 w_issue;
    logic                 w_stall;
    logic [1:0]           w_raddr2;
    logic                 w_fwd;

    // ---------------- write arbitration and stage ----------------
    assign w_conflict = io_bus.core_wvalid & io_bus.host_wvalid;
    assign w_core_gnt = io_bus.core_wvalid & (~io_bus.host_wvalid | r_last_host);
    assign w_host_gnt = io_bus.host_wvalid & (~io_bus.core_wvalid | ~r_last_host);

    // Pointer starts at "host last" so the core wins the first conflict.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_last_host <= 1'b1;
            r_stg_valid <= 1'b0;
            r_stg_addr  <= 2'd0;
            r_stg_data  <= '0;
        end else begin
            if (w_conflict) begin
                r_last_host <= w_host_gnt;
            end
            r_stg_valid <= w_core_gnt | w_host_gnt;
            if (w_core_gnt) begin
                r_stg_addr <= io_bus.core_waddr;
                r_stg_data <= io_bus.core_wdata;
            end else if (w_host_gnt) begin
                r_stg_addr <= io_bus.host_waddr;
                r_stg_data <= io_bus.host_wdata;
            end
        end
    end

    // ---------------- host read FSM ----------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rready    = 1'b0;
        w_issue     = 1'b0;
        w_stall     = 1'b0;
        w_raddr2    = io_bus.core_raddr2;
        w_cnt_max   = (r_wait_cnt == c_WAIT_MAX);
        case (r_state)
            R_IDLE: begin
                w_rready = 1'b1;
                if (io_bus.host_rvalid) begin
                    w_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                w_issue = io_bus.core_rd2_idle | w_cnt_max;
                w_stall = w_cnt_max & ~io_bus.core_rd2_idle;
                if (w_issue) begin
                    w_raddr2    = r_raddr;
                    w_state_nxt = R_IDLE;
                end
            end
            default: begin
                w_state_nxt = R_IDLE;
            end
        endcase
    end

    assign w_accept = w_rready & io_bus.host_rvalid;
    // The staged write lands in the file at the next edge, so it is newer
    // than what port 2 shows this cycle.
    assign w_fwd    = r_stg_valid & (r_stg_addr == r_raddr);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_raddr    <= 2'd0;
            r_wait_cnt <= '0;
            r_rdata    <= '0;
            r_rdvalid  <= 1'b0;
        end else begin
            r_rdvalid <= w_issue;
            if (w_accept) begin
                r_raddr    <= io_bus.host_raddr;
                r_wait_cnt <= '0;
            end else if ((r_state == R_WAIT) && !w_issue && !w_cnt_max) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
            end
            if (w_issue) begin
                r_rdata <= w_fwd ? r_stg_data : io_bus.rf_rdata2;
            end
        end
    end

    // ---------------- outputs ----------------
    assign io_bus.core_wready  = w_core_gnt;
    assign io_bus.host_wready  = w_host_gnt;
    assign io_bus.host_rready  = w_rready;
    assign io_bus.host_rdata   = r_rdata;
    assign io_bus.host_rdvalid = r_rdvalid;
    assign io_bus.core_stall   = w_stall;
    assign io_bus.rf_w         = r_stg_valid;
    assign io_bus.rf_waddr     = r_stg_addr;
    assign io_bus.rf_wdata     = r_stg_data;
    assign io_bus.rf_raddr2    = w_raddr2;

endmodule

`default_nettype wire
